// File: rtl/rtc_bus_controller_if.sv
// Request/response handshake between the time-write/time-read FSMs and the RTC bus controller.
// Latency: none (wires only).
// Backpressure: none; the controller ignores flag_rtc outside IDLE and answers with siga.
//
// Ports (master = requesting FSM, slave = rtc_bus_controller):
//   flag_rtc    request / ownership
//   lea_escriba 0 = read, 1 = write
//   direc       RTC register address
//   dato_smh    write data
//   rtc         last read data
//   tome        1-cycle pulse when rtc is updated
//   siga        idle high, 1-cycle low pulse on completion
interface rtc_bus_controller_if;
   logic       flag_rtc;
   logic       lea_escriba;
   logic [7:0] direc;
   logic [7:0] dato_smh;
   logic [7:0] rtc;
   logic       tome;
   logic       siga;

   modport master (
      output flag_rtc, lea_escriba, direc, dato_smh,
      input  rtc, tome, siga
   );

   modport slave (
      input  flag_rtc, lea_escriba, direc, dato_smh,
      output rtc, tome, siga
   );
endinterface

// File: rtl/rtc_bus_controller.sv
// Responder that runs one address-multiplexed RTC bus cycle (address phase, data phase) per request.
// Latency: 1 + 2*T_SETUP + 2*T_STROBE + 2*T_HOLD cycles from request sampled to siga low (+1 with RTC_CS_SPLIT_EN).
// Backpressure: one transaction at a time; flag_rtc is only sampled in IDLE, ignored during T_REARM after siga.
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   req            request handshake (rtc_bus_controller_if.slave)
//   cs_n, ad       chip select (active-low), 0 = address phase / 1 = data phase
//   wr_n, rd_n     write / read strobes (active-low)
//   bus_out/bus_oe value for the AD bus and its output enable; bus_in is the sampled AD bus
//
// Optional build macro RTC_CS_SPLIT_EN: inserts a one-cycle CS_GAP (cs_n high, bus released)
// between the address and data phases.
module rtc_bus_controller #(
   parameter int T_SETUP  = 2,   // >= 1
   parameter int T_STROBE = 10,  // >= 2
   parameter int T_HOLD   = 2,   // >= 1
   parameter int T_REARM  = 2    // >= 2
) (
   input  logic                       clk,
   input  logic                       reset,
   rtc_bus_controller_if.slave        req,
   output logic                       cs_n,
   output logic                       ad,
   output logic                       wr_n,
   output logic                       rd_n,
   output logic [7:0]                 bus_out,
   output logic                       bus_oe,
   input  logic [7:0]                 bus_in
);

   // The counter holds "cycles left minus one" in the current phase.
   localparam int T_MAX_SH = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
   localparam int T_MAX_SR = (T_STROBE > T_REARM) ? T_STROBE : T_REARM;
   localparam int T_MAX    = (T_MAX_SH > T_MAX_SR) ? T_MAX_SH : T_MAX_SR;
   localparam int CW       = $clog2(T_MAX);

   localparam logic [CW-1:0] LD_SETUP  = CW'(T_SETUP - 1);
   localparam logic [CW-1:0] LD_STROBE = CW'(T_STROBE - 1);
   localparam logic [CW-1:0] LD_HOLD   = CW'(T_HOLD - 1);
   localparam logic [CW-1:0] LD_REARM  = CW'(T_REARM - 1);

   typedef enum logic [3:0] {
      IDLE, A_SETUP, A_STROBE, A_HOLD, CS_GAP,
      D_SETUP, D_STROBE, D_HOLD, DONE, REARM
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          last;

   logic [7:0]    cap_addr, cap_addr_nxt;
   logic [7:0]    cap_data, cap_data_nxt;
   logic          cap_wr, cap_wr_nxt;

   logic [7:0]    rtc_q, rtc_nxt;
   logic          tome_q, tome_nxt;
   logic          siga_q, siga_nxt;
   logic          cs_n_nxt, ad_nxt, wr_n_nxt, rd_n_nxt, bus_oe_nxt;
   logic [7:0]    bus_out_nxt;

   assign req.rtc  = rtc_q;
   assign req.tome = tome_q;
   assign req.siga = siga_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         cap_addr <= 8'h00;
         cap_data <= 8'h00;
         cap_wr   <= 1'b0;
         rtc_q    <= 8'h00;
         tome_q   <= 1'b0;
         siga_q   <= 1'b1;
         cs_n     <= 1'b1;
         ad       <= 1'b0;
         wr_n     <= 1'b1;
         rd_n     <= 1'b1;
         bus_out  <= 8'h00;
         bus_oe   <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         cap_addr <= cap_addr_nxt;
         cap_data <= cap_data_nxt;
         cap_wr   <= cap_wr_nxt;
         rtc_q    <= rtc_nxt;
         tome_q   <= tome_nxt;
         siga_q   <= siga_nxt;
         cs_n     <= cs_n_nxt;
         ad       <= ad_nxt;
         wr_n     <= wr_n_nxt;
         rd_n     <= rd_n_nxt;
         bus_out  <= bus_out_nxt;
         bus_oe   <= bus_oe_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      last         = (cnt == '0);
      cnt_nxt      = last ? cnt : cnt - 1'b1;
      cap_addr_nxt = cap_addr;
      cap_data_nxt = cap_data;
      cap_wr_nxt   = cap_wr;
      rtc_nxt      = rtc_q;
      tome_nxt     = 1'b0;

      case (state)
         IDLE: begin
            if (req.flag_rtc) begin
               cap_addr_nxt = req.direc;
               cap_data_nxt = req.dato_smh;
               cap_wr_nxt   = req.lea_escriba;
               state_nxt    = A_SETUP;
               cnt_nxt      = LD_SETUP;
            end
         end
         A_SETUP: if (last) begin state_nxt = A_STROBE; cnt_nxt = LD_STROBE; end
         A_STROBE: if (last) begin state_nxt = A_HOLD; cnt_nxt = LD_HOLD; end
         A_HOLD: begin
            if (last) begin
`ifdef RTC_CS_SPLIT_EN
               state_nxt = CS_GAP;
`else
               state_nxt = D_SETUP;
               cnt_nxt   = LD_SETUP;
`endif
            end
         end
         CS_GAP: begin
            state_nxt = D_SETUP;
            cnt_nxt   = LD_SETUP;
         end
         D_SETUP: if (last) begin state_nxt = D_STROBE; cnt_nxt = LD_STROBE; end
         D_STROBE: begin
            if (last) begin
               // Read data is taken at the end of the strobe so the RTC has
               // the full strobe width to drive the bus.
               if (!cap_wr) begin
                  rtc_nxt  = bus_in;
                  tome_nxt = 1'b1;
               end
               state_nxt = D_HOLD;
               cnt_nxt   = LD_HOLD;
            end
         end
         D_HOLD: if (last) state_nxt = DONE;
         DONE: begin
            state_nxt = REARM;
            cnt_nxt   = LD_REARM;
         end
         REARM: if (last) state_nxt = IDLE;
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase

      // Pin values are decoded from the next state so every output is a flop
      // that lines up with the state it belongs to.
      cs_n_nxt    = 1'b1;
      ad_nxt      = 1'b0;
      wr_n_nxt    = 1'b1;
      rd_n_nxt    = 1'b1;
      bus_out_nxt = 8'h00;
      bus_oe_nxt  = 1'b0;
      siga_nxt    = 1'b1;

      case (state_nxt)
         A_SETUP, A_HOLD, A_STROBE: begin
            cs_n_nxt    = 1'b0;
            bus_oe_nxt  = 1'b1;
            bus_out_nxt = cap_addr_nxt;
            // The RTC address latch is clocked by wr_n for both reads and writes.
            wr_n_nxt    = (state_nxt != A_STROBE);
         end
         D_SETUP, D_STROBE, D_HOLD: begin
            cs_n_nxt    = 1'b0;
            ad_nxt      = 1'b1;
            bus_oe_nxt  = cap_wr_nxt;
            bus_out_nxt = cap_wr_nxt ? cap_data_nxt : 8'h00;
            if (state_nxt == D_STROBE) begin
               wr_n_nxt = !cap_wr_nxt;
               rd_n_nxt = cap_wr_nxt;
            end
         end
         DONE: siga_nxt = 1'b0;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rtc_bus_controller.sv
// Directed bench for rtc_bus_controller: write, read, back-to-back, input change, mid-transaction reset.
// Latency: each transaction is traced cycle by cycle from the edge that samples the request.
// Backpressure: flag_rtc is held or dropped by the bench; every wait is a bounded cycle loop.
module tb_rtc_bus_controller;

`ifdef RTC_CS_SPLIT_EN
   localparam int G = 1;
`else
   localparam int G = 0;
`endif

   logic       clk;
   logic       reset;
   logic       cs_n, ad, wr_n, rd_n, bus_oe;
   logic [7:0] bus_out, bus_in;

   rtc_bus_controller_if req_if ();

   rtc_bus_controller dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req_if),
      .cs_n    (cs_n),
      .ad      (ad),
      .wr_n    (wr_n),
      .rd_n    (rd_n),
      .bus_out (bus_out),
      .bus_oe  (bus_oe),
      .bus_in  (bus_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   int         siga_q[$];
   int         tome_q[$];
   logic [7:0] addr_q[$];
   logic [7:0] data_q[$];
   int         a_wr, d_wr, d_rd, cs_low, cs_rise, viol;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Trace n cycles; k = 1 is the edge that samples a request presented just before it.
   task automatic trace(input int n, input int drop_at, input int chg_at, input int rd_at, input logic b2b);
      logic prev_cs, prev_a, prev_d, cur_a, cur_d;
      int   nb;
      siga_q.delete(); tome_q.delete(); addr_q.delete(); data_q.delete();
      a_wr = 0; d_wr = 0; d_rd = 0; cs_low = 0; cs_rise = 0; viol = 0;
      prev_cs = 1'b1; prev_a = 1'b0; prev_d = 1'b0; nb = 0;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         if (!req_if.siga) siga_q.push_back(k);
         if (req_if.tome)  tome_q.push_back(k);
         if (!cs_n) cs_low++;
         if (cs_n && !prev_cs) cs_rise++;
         cur_a = !cs_n && !ad;
         cur_d = !cs_n && ad && bus_oe;
         if (cur_a && (!prev_a || bus_out != addr_q[$])) addr_q.push_back(bus_out);
         if (cur_d && (!prev_d || bus_out != data_q[$])) data_q.push_back(bus_out);
         if (!wr_n && !cs_n && !ad) a_wr++;
         if (!wr_n && !cs_n && ad)  d_wr++;
         if (!rd_n) d_rd++;
         if ((!wr_n && !rd_n) || (bus_oe && !rd_n)) viol++;
         prev_cs = cs_n; prev_a = cur_a; prev_d = cur_d;
         // stimulus for the cycle that follows edge k
         if (k == drop_at) req_if.flag_rtc = 1'b0;
         if (k == chg_at) begin
            req_if.direc    = 8'hFF;
            req_if.dato_smh = 8'h00;
         end
         if (rd_at != 0) bus_in = (k == rd_at) ? 8'hA7 : 8'h10 + 8'(k);
         if (b2b && !req_if.siga) begin
            nb++;
            if (nb == 3) req_if.flag_rtc = 1'b0;
            else         req_if.direc = req_if.direc + 8'h01;
         end
      end
   endtask

   task automatic start(input logic wr, input logic [7:0] a, input logic [7:0] d);
      req_if.lea_escriba = wr;
      req_if.direc       = a;
      req_if.dato_smh    = d;
      req_if.flag_rtc    = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      req_if.flag_rtc = 1'b0; req_if.lea_escriba = 1'b0;
      req_if.direc = 8'h00; req_if.dato_smh = 8'h00;
      bus_in = 8'h00;
      #2 reset = 1'b0;
      #10;
      chk("rst_siga", req_if.siga, 1'b1);
      chk("rst_tome", req_if.tome, 1'b0);
      chk("rst_rtc", req_if.rtc, 8'h00);
      chk("rst_strobes", {cs_n, wr_n, rd_n}, 3'b111);
      chk("rst_ad_oe", {ad, bus_oe}, 2'b00);
      chk("rst_bus_out", bus_out, 8'h00);
      @(posedge clk); #3 reset = 1'b1;
      @(posedge clk); #1;

      // Write 8'h45 to 8'h21
      start(1'b1, 8'h21, 8'h45);
      trace(40, 1, 0, 0, 1'b0);
      chk("w_siga_cnt", siga_q.size(), 1);
      chk("w_siga_at", siga_q.size() > 0 ? siga_q[0] : -1, 29 + G);
      chk("w_tome_cnt", tome_q.size(), 0);
      chk("w_addr_cnt", addr_q.size(), 1);
      chk("w_addr", addr_q.size() > 0 ? addr_q[0] : 8'hxx, 8'h21);
      chk("w_data_cnt", data_q.size(), 1);
      chk("w_data", data_q.size() > 0 ? data_q[0] : 8'hxx, 8'h45);
      chk("w_a_wr_low", a_wr, 10);
      chk("w_d_wr_low", d_wr, 10);
      chk("w_rd_low", d_rd, 0);
      chk("w_cs_low", cs_low, 28);
      chk("w_cs_rise", cs_rise, 1 + G);
      chk("w_viol", viol, 0);

      // Read from 8'h00; A7 only appears on the final D_STROBE cycle
      bus_in = 8'h10;
      start(1'b0, 8'h00, 8'h99);
      trace(40, 1, 0, 26 + G, 1'b0);
      chk("r_rtc", req_if.rtc, 8'hA7);
      chk("r_tome_cnt", tome_q.size(), 1);
      chk("r_tome_at", tome_q.size() > 0 ? tome_q[0] : -1, 27 + G);
      chk("r_siga_at", siga_q.size() > 0 ? siga_q[0] : -1, 29 + G);
      chk("r_rd_low", d_rd, 10);
      chk("r_d_wr_low", d_wr, 0);
      chk("r_a_wr_low", a_wr, 10);
      chk("r_addr", addr_q.size() > 0 ? addr_q[0] : 8'hxx, 8'h00);
      chk("r_data_driven", data_q.size(), 0);
      chk("r_viol", viol, 0);

      // Write after read leaves rtc alone
      start(1'b1, 8'h34, 8'h5A);
      trace(40, 1, 0, 0, 1'b0);
      chk("w2_rtc_hold", req_if.rtc, 8'hA7);
      chk("w2_tome_cnt", tome_q.size(), 0);
      chk("w2_data", data_q.size() > 0 ? data_q[0] : 8'hxx, 8'h5A);

      // Back-to-back with flag_rtc held high
      start(1'b1, 8'h21, 8'h45);
      trace(110, 0, 0, 0, 1'b1);
      chk("bb_siga_cnt", siga_q.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("bb_siga_at%0d", i), siga_q.size() > i ? siga_q[i] : -1, 29 + G + i * (32 + G));
         chk($sformatf("bb_addr%0d", i), addr_q.size() > i ? addr_q[i] : 8'hxx, 8'h21 + 8'(i));
      end
      chk("bb_addr_cnt", addr_q.size(), 3);
      chk("bb_cs_low", cs_low, 3 * 28);
      chk("bb_viol", viol, 0);

      // Inputs change and request drops 5 cycles into a write
      start(1'b1, 8'h22, 8'h5C);
      trace(45, 5, 5, 0, 1'b0);
      chk("ic_addr_cnt", addr_q.size(), 1);
      chk("ic_addr", addr_q.size() > 0 ? addr_q[0] : 8'hxx, 8'h22);
      chk("ic_data", data_q.size() > 0 ? data_q[0] : 8'hxx, 8'h5C);
      chk("ic_siga_at", siga_q.size() > 0 ? siga_q[0] : -1, 29 + G);
      chk("ic_cs_low", cs_low, 28);

      // Reset in D_STROBE of a write
      start(1'b1, 8'h44, 8'h66);
      repeat (20) @(posedge clk);
      #1;
      req_if.flag_rtc = 1'b0;
      chk("mr_in_strobe", {cs_n, ad, wr_n}, 3'b010);
      reset = 1'b0;
      #1;
      chk("mr_strobes_high", {cs_n, wr_n, rd_n}, 3'b111);
      chk("mr_oe_off", bus_oe, 1'b0);
      chk("mr_siga", req_if.siga, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("mr_siga_held", req_if.siga, 1'b1);
      chk("mr_rtc_clr", req_if.rtc, 8'h00);
      reset = 1'b1;
      @(posedge clk); #1;
      start(1'b1, 8'h33, 8'h77);
      trace(40, 1, 0, 0, 1'b0);
      chk("mr_new_siga_at", siga_q.size() > 0 ? siga_q[0] : -1, 29 + G);
      chk("mr_new_addr", addr_q.size() > 0 ? addr_q[0] : 8'hxx, 8'h33);
      chk("mr_new_data", data_q.size() > 0 ? data_q[0] : 8'hxx, 8'h77);
      chk("mr_new_cs_low", cs_low, 28);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
